dictionary_sequencer: RTL and testbench
=======================================

# dictionary_sequencer

Walks the dictionary held in external SRAM and streams it, word by word, into the Levenshtein engine datapath. It sits between the memory-side Wishbone bus (as a read-only master) and the engine's character input. It starts when the engine controller sets `enabled`. It tracks the smallest distance reported by the engine and the index of the word that produced it. It exposes busy, done and error status for the host register map.

## Interface

**Parameters**
- `DICT_BASE`, default 16'h0000: byte address of the first dictionary byte.
- `ADDR_WIDTH`, default 16: Wishbone address width.

**Ports**
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `enabled` in 1: run request from the engine controller.
- `cyc_o` out 1: Wishbone master cycle.
- `stb_o` out 1: Wishbone master strobe.
- `we_o` out 1: Wishbone write enable; tied 0.
- `adr_o` out ADDR_WIDTH: read address.
- `dat_i` in 8: read data.
- `ack_i` in 1: read acknowledge.
- `err_i` in 1: bus error.
- `word_start_o` out 1: one-cycle pulse; the engine clears its row for a new word.
- `char_o` out 8: dictionary character.
- `char_valid_o` out 1: one-cycle pulse; `char_o` is valid.
- `word_end_o` out 1: one-cycle pulse; the engine finishes the current word.
- `distance_i` in 8: engine result.
- `distance_valid_i` in 1: one-cycle pulse; `distance_i` is valid.
- `busy_o` out 1: scan in progress.
- `done_o` out 1: scan completed; sticky until the next start.
- `error_o` out 1: bus error or address overflow; sticky until the next start.
- `best_distance_o` out 8: smallest distance seen so far.
- `best_index_o` out 16: index of the word that produced `best_distance_o`.

## Operation

**Dictionary format**
- A byte sequence starting at `DICT_BASE`.
- 8'h00 terminates a word.
- 8'h01 terminates the dictionary.
- Any other value is a character.

**Start**
- A rising edge of `enabled` while in IDLE starts a scan.
- On start: `adr_o`=DICT_BASE, word index=0, `best_distance_o`=8'hFF, `best_index_o`=0, `done_o`=0, `error_o`=0.

**States**
- IDLE:
  - Waits for the start condition.
  - On start: pulse `word_start_o`, go to FETCH.
- FETCH:
  - Asserts `cyc_o`/`stb_o` with `adr_o` held.
  - `ack_i`: register `dat_i`, deassert `cyc_o`/`stb_o` on the next edge, go to DISPATCH.
  - `err_i`: set `error_o`, go to DONE.
- DISPATCH:
  - Character: `char_o`=byte, pulse `char_valid_o`, `adr_o`++, go to FETCH.
  - 8'h00: pulse `word_end_o`, `adr_o`++, go to WAIT_DIST.
  - 8'h01: go to DONE. A partial word (characters sent since the last `word_start_o`) is discarded and gets no distance.
- WAIT_DIST:
  - Waits for `distance_valid_i`.
  - If `distance_i` < `best_distance_o` (strictly less, so the first occurrence wins on ties): update `best_distance_o` and `best_index_o`.
  - Then increment the word index.
  - If `distance_i`==0: go to DONE (early exit).
  - Otherwise: pulse `word_start_o`, go to FETCH.
- DONE:
  - `busy_o`=0, `done_o`=1.
  - Returns to IDLE when `enabled`=0.

**Status and boundary rules**
- `busy_o`=1 in every state except IDLE and DONE.
- Abort: if `enabled` falls during FETCH, the outstanding bus cycle completes on `ack_i`/`err_i`, then the block goes to IDLE with `done_o`=0. In any other state it goes to IDLE on the next edge.
- Address overflow: a dispatch of a non-terminator byte at `adr_o`=all-ones sets `error_o` and goes to DONE. The address never wraps.
- An empty word (8'h00 immediately after `word_start_o`) is legal. It still gets `word_end_o` and a distance.
- The word index saturates at 16'hFFFF.

## Timing

**Reset values**
- All outputs 0, except `best_distance_o`=8'hFF and `adr_o`=DICT_BASE.
- State is IDLE.
- `rst_i` mid-scan drops `cyc_o`/`stb_o` in the same edge.

**Latencies**
- Start edge to first `stb_o`: 2 cycles (IDLE→FETCH with `word_start_o` in between).
- Per character with zero-wait memory (`ack_i` in the cycle after `stb_o`): 3 cycles (FETCH, ack edge, DISPATCH).

**Handshake timing**
- `word_start_o`, `char_valid_o` and `word_end_o` are never asserted together.
- The engine accepts one character per pulse and needs no backpressure.
- `distance_valid_i` outside WAIT_DIST is ignored.
- `best_*` update on the edge that samples `distance_valid_i`.
- `done_o` rises on the following edge when the exit is by terminator or by distance 0.

## Structure

- `levenshtein_pkg` holds:
  - the state enum;
  - `WORD_END`=8'h00;
  - `DICT_END`=8'h01;
  - `DIST_NONE`=8'hFF.
- Sub-module `best_match_tracker` holds the compare/update of `best_distance`/`best_index` and the word index counter, with clear and update strobes.
- The FSM and the bus master stay in the top-level module.

## Test plan

- Dictionary "ab\0cd\0\x01", engine returns 2 then 1 → `best_distance_o`=1, `best_index_o`=1, `done_o`=1, four `char_valid_o` pulses, two `word_end_o` pulses.
- Distances 3, 1, 1 for three words → `best_index_o`=1 (tie keeps the first).
- Second word returns distance 0 → `done_o` is set without fetching any byte of the third word; `best_index_o`=1.
- `err_i` on the third read → `error_o`=1, `done_o`=1, `cyc_o`=0 on the next cycle.
- `enabled` drops while `stb_o` is high with `ack_i` delayed 4 cycles → the cycle completes, the block returns to IDLE, `done_o`=0.
- DICT_BASE=16'hFFFE with bytes "xy" and no terminator → `error_o`=1 after the byte at 16'hFFFF; `adr_o` is never 0.

Source files
------------

// File: rtl/levenshtein_pkg.sv
// Shared types and constants for the dictionary sequencer and its best-match tracker.
//   seq_state_e : sequencer FSM states
//   WORD_END    : dictionary byte that closes a word
//   DICT_END    : dictionary byte that closes the dictionary
//   DIST_NONE   : "no distance yet" value for the best-distance register
package levenshtein_pkg;

    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned INDEX_W = 16;

    localparam logic [CHAR_W-1:0] WORD_END  = 8'h00;
    localparam logic [CHAR_W-1:0] DICT_END  = 8'h01;
    localparam logic [CHAR_W-1:0] DIST_NONE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISPATCH,
        ST_WAIT_DIST,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/best_match_tracker.sv
// Keeps the smallest engine distance seen during a scan and the index of the word
// that produced it, plus the running word index.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear          : start of a new scan; restores the "no match" state
//   update         : one distance result for the current word
//   distance       : engine distance for the current word
//   best_distance  : smallest distance so far (DIST_NONE when none)
//   best_index     : index of the word that produced best_distance
module best_match_tracker
    import levenshtein_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear,
    input  logic               update,
    input  logic [CHAR_W-1:0]  distance,
    output logic [CHAR_W-1:0]  best_distance,
    output logic [INDEX_W-1:0] best_index
);

    logic [INDEX_W-1:0] word_index;

    // Strict less-than keeps the earliest word on ties; the index saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            best_distance <= DIST_NONE;
            best_index    <= '0;
            word_index    <= '0;
        end else if (update) begin
            if (distance < best_distance) begin
                best_distance <= distance;
                best_index    <= word_index;
            end
            if (word_index != '1) begin
                word_index <= word_index + INDEX_W'(1);
            end
        end
    end

endmodule

// File: rtl/dictionary_sequencer.sv
// Walks a dictionary in external memory over a read-only Wishbone master and
// streams it word by word into the Levenshtein engine, tracking the best match.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   enabled                      : run request (rising edge starts a scan)
//   cyc_o/stb_o/we_o/adr_o       : Wishbone master request (read only)
//   dat_i/ack_i/err_i            : Wishbone read data and response
//   word_start_o/char_o/
//   char_valid_o/word_end_o      : engine character stream (one-cycle pulses)
//   distance_i/distance_valid_i  : engine result per word
//   busy_o/done_o/error_o        : scan status (done/error sticky until next start)
//   best_distance_o/best_index_o : best match so far
module dictionary_sequencer
    import levenshtein_pkg::*;
#(
    parameter logic [15:0] DICT_BASE  = 16'h0000,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enabled,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    input  logic [CHAR_W-1:0]     dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    output logic                  word_start_o,
    output logic [CHAR_W-1:0]     char_o,
    output logic                  char_valid_o,
    output logic                  word_end_o,
    input  logic [CHAR_W-1:0]     distance_i,
    input  logic                  distance_valid_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [CHAR_W-1:0]     best_distance_o,
    output logic [INDEX_W-1:0]    best_index_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE_ADR = ADDR_WIDTH'(DICT_BASE);

    seq_state_e        state;
    logic              enabled_q;
    logic              abort_q;     // enabled dropped while a bus cycle was outstanding
    logic              last_adr_q;  // word ended at the top address; nothing left to fetch
    logic [CHAR_W-1:0] byte_q;
    logic              start_c;
    logic              track_update_c;

    assign start_c        = (state == ST_IDLE) && enabled && !enabled_q;
    assign track_update_c = (state == ST_WAIT_DIST) && enabled && distance_valid_i;
    assign we_o           = 1'b0;

    best_match_tracker u_tracker (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear         (start_c),
        .update        (track_update_c),
        .distance      (distance_i),
        .best_distance (best_distance_o),
        .best_index    (best_index_o)
    );

    // Sequencer FSM and Wishbone master.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            enabled_q    <= 1'b0;
            abort_q      <= 1'b0;
            last_adr_q   <= 1'b0;
            byte_q       <= '0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            adr_o        <= BASE_ADR;
            word_start_o <= 1'b0;
            char_o       <= '0;
            char_valid_o <= 1'b0;
            word_end_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            enabled_q    <= enabled;
            word_start_o <= 1'b0;
            char_valid_o <= 1'b0;
            word_end_o   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        adr_o        <= BASE_ADR;
                        done_o       <= 1'b0;
                        error_o      <= 1'b0;
                        abort_q      <= 1'b0;
                        last_adr_q   <= 1'b0;
                        busy_o       <= 1'b1;
                        word_start_o <= 1'b1;
                        state        <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (!stb_o) begin
                        // No cycle outstanding yet, so an abort can leave immediately.
                        if (!enabled) begin
                            busy_o <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                        end
                    end else begin
                        if (!enabled) begin
                            abort_q <= 1'b1;
                        end
                        if (ack_i || err_i) begin
                            cyc_o  <= 1'b0;
                            stb_o  <= 1'b0;
                            byte_q <= dat_i;
                            if (!enabled || abort_q) begin
                                busy_o <= 1'b0;
                                state  <= ST_IDLE;
                            end else if (err_i) begin
                                error_o <= 1'b1;
                                busy_o  <= 1'b0;
                                state   <= ST_DONE;
                            end else begin
                                state <= ST_DISPATCH;
                            end
                        end
                    end
                end

                ST_DISPATCH: begin
                    if (!enabled) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (byte_q == DICT_END) begin
                        busy_o <= 1'b0;
                        state  <= ST_DONE;
                    end else if (byte_q == WORD_END) begin
                        word_end_o <= 1'b1;
                        if (adr_o == '1) begin
                            last_adr_q <= 1'b1;
                        end else begin
                            adr_o <= adr_o + ADDR_WIDTH'(1);
                        end
                        state <= ST_WAIT_DIST;
                    end else if (adr_o == '1) begin
                        // Character at the top address: the next fetch would wrap.
                        error_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        char_o       <= byte_q;
                        char_valid_o <= 1'b1;
                        adr_o        <= adr_o + ADDR_WIDTH'(1);
                        state        <= ST_FETCH;
                    end
                end

                ST_WAIT_DIST: begin
                    if (!enabled) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (distance_valid_i) begin
                        if (distance_i == '0) begin
                            busy_o <= 1'b0;
                            state  <= ST_DONE;
                        end else if (last_adr_q) begin
                            error_o <= 1'b1;
                            busy_o  <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            word_start_o <= 1'b1;
                            state        <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    if (!enabled) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dictionary_sequencer.sv
// Self-checking bench for dictionary_sequencer: memory slave, engine model with a
// character scoreboard, a vector table of whole scans and hand-written corner cases.
module tb_dictionary_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enabled = 1'b0;
    logic        cyc_o, stb_o, we_o;
    logic [15:0] adr_o;
    logic [7:0]  dat_i = 8'h00;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        word_start_o, char_valid_o, word_end_o;
    logic [7:0]  char_o;
    logic [7:0]  distance_i = 8'h00;
    logic        distance_valid_i = 1'b0;
    logic        busy_o, done_o, error_o;
    logic [7:0]  best_distance_o;
    logic [15:0] best_index_o;

    // Second instance placed at the top of the address space.
    logic        en_h = 1'b0;
    logic        cyc_h, stb_h, we_h;
    logic [15:0] adr_h;
    logic [7:0]  dat_h = 8'h00;
    logic        ack_h = 1'b0;
    logic        err_h = 1'b0;
    logic        ws_h, cv_h, we_end_h;
    logic [7:0]  char_h;
    logic [7:0]  dist_h = 8'h00;
    logic        dv_h = 1'b0;
    logic        busy_h, done_h, error_h;
    logic [7:0]  bd_h;
    logic [15:0] bi_h;

    always #5 clk_i = ~clk_i;

    dictionary_sequencer #(.DICT_BASE(16'h0000), .ADDR_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enabled(enabled),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
        .word_start_o(word_start_o), .char_o(char_o), .char_valid_o(char_valid_o),
        .word_end_o(word_end_o), .distance_i(distance_i), .distance_valid_i(distance_valid_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .best_distance_o(best_distance_o), .best_index_o(best_index_o)
    );

    dictionary_sequencer #(.DICT_BASE(16'hFFFE), .ADDR_WIDTH(16)) dut_hi (
        .clk_i(clk_i), .rst_i(rst_i), .enabled(en_h),
        .cyc_o(cyc_h), .stb_o(stb_h), .we_o(we_h), .adr_o(adr_h),
        .dat_i(dat_h), .ack_i(ack_h), .err_i(err_h),
        .word_start_o(ws_h), .char_o(char_h), .char_valid_o(cv_h),
        .word_end_o(we_end_h), .distance_i(dist_h), .distance_valid_i(dv_h),
        .busy_o(busy_h), .done_o(done_h), .error_o(error_h),
        .best_distance_o(bd_h), .best_index_o(bi_h)
    );

    logic [7:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory slave for the main instance: optional wait states and error injection.
    int ack_delay   = 0;
    int err_on_read = 0;
    int reads       = 0;
    int wait_cnt    = 0;
    always @(negedge clk_i) begin
        if (cyc_o && stb_o && !ack_i && !err_i) begin
            if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                reads++;
                if (reads == err_on_read) begin
                    err_i = 1'b1;
                end else begin
                    ack_i = 1'b1;
                    dat_i = mem[adr_o];
                end
            end
        end else begin
            ack_i    = 1'b0;
            err_i    = 1'b0;
            wait_cnt = 0;
        end
    end

    // Engine model: returns queued distances two cycles after word_end, drives a
    // stray distance 0 right after each word_start, and scoreboards the characters.
    logic [7:0] dist_q[$];
    logic [7:0] exp_char_q[$];
    int n_chars = 0;
    int n_ends  = 0;
    int dist_cd = 0;
    always @(negedge clk_i) begin
        distance_valid_i = 1'b0;
        if (dist_cd > 0) begin
            dist_cd--;
            if (dist_cd == 0) begin
                distance_valid_i = 1'b1;
                distance_i = (dist_q.size() > 0) ? dist_q.pop_front() : 8'hFF;
            end
        end
        if (word_start_o) begin
            distance_valid_i = 1'b1;
            distance_i = 8'h00;
        end
        if (word_end_o) begin
            n_ends++;
            dist_cd = 2;
        end
        if (char_valid_o) begin
            n_chars++;
            if (exp_char_q.size() == 0) check("char_extra", 32'(char_o), 32'h100);
            else check("char_value", 32'(char_o), 32'(exp_char_q.pop_front()));
        end
        if (word_start_o || char_valid_o || word_end_o)
            check("pulse_exclusive", 32'(word_start_o) + 32'(char_valid_o) + 32'(word_end_o), 32'd1);
    end

    // Zero-wait slave and monitors for the high instance.
    int  reads_h     = 0;
    int  n_chars_h   = 0;
    bit  adr_zero_h  = 1'b0;
    always @(negedge clk_i) begin
        if (cyc_h && stb_h && !ack_h) begin
            ack_h = 1'b1;
            dat_h = mem[adr_h];
            reads_h++;
        end else begin
            ack_h = 1'b0;
        end
        if (cv_h) n_chars_h++;
        if (!rst_i && adr_h == 16'h0000) adr_zero_h = 1'b1;
    end

    typedef struct {
        logic [95:0] dict;     // bytes, first byte most significant
        int          n_bytes;
        logic [31:0] dists;    // engine replies, first most significant
        int          nd;
        logic [7:0]  exp_bd;
        logic [15:0] exp_bi;
        logic        exp_err;
        int          exp_chars;
        int          exp_ends;
        int          exp_reads;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        bit ok;
        int w;
        logic [7:0] b;
        v = vecs[idx];
        exp_char_q.delete();
        dist_q.delete();
        for (int i = 0; i < v.n_bytes; i++) mem[i] = v.dict[8*(v.n_bytes-1-i) +: 8];
        for (int k = 0; k < v.nd; k++) dist_q.push_back(v.dists[8*(v.nd-1-k) +: 8]);
        // Expected character stream, honouring early exit on distance 0.
        w = 0;
        for (int i = 0; i < v.n_bytes; i++) begin
            b = mem[i];
            if (b == 8'h01) break;
            if (b == 8'h00) begin
                if (w < v.nd && v.dists[8*(v.nd-1-w) +: 8] == 8'h00) break;
                w++;
            end else begin
                exp_char_q.push_back(b);
            end
        end
        n_chars = 0;
        n_ends  = 0;
        reads   = 0;
        enabled = 1'b1;
        @(negedge clk_i);
        check($sformatf("v%0d_word_start", idx), 32'(word_start_o), 32'd1);
        check($sformatf("v%0d_stb_early", idx), 32'(stb_o), 32'd0);
        check($sformatf("v%0d_busy", idx), 32'(busy_o), 32'd1);
        @(negedge clk_i);
        check($sformatf("v%0d_first_stb", idx), {30'd0, cyc_o, stb_o}, 32'd3);
        wait_done(2000, ok);
        check($sformatf("v%0d_done_seen", idx), 32'(ok), 32'd1);
        check($sformatf("v%0d_best_dist", idx), 32'(best_distance_o), 32'(v.exp_bd));
        check($sformatf("v%0d_best_idx", idx), 32'(best_index_o), 32'(v.exp_bi));
        check($sformatf("v%0d_error", idx), 32'(error_o), 32'(v.exp_err));
        check($sformatf("v%0d_idle_bus", idx), {29'd0, busy_o, cyc_o, stb_o}, 32'd0);
        check($sformatf("v%0d_chars", idx), 32'(n_chars), 32'(v.exp_chars));
        check($sformatf("v%0d_ends", idx), 32'(n_ends), 32'(v.exp_ends));
        check($sformatf("v%0d_reads", idx), 32'(reads), 32'(v.exp_reads));
        check($sformatf("v%0d_chars_left", idx), 32'(exp_char_q.size()), 32'd0);
        enabled = 1'b0;
        repeat (2) @(negedge clk_i);
        check($sformatf("v%0d_done_sticky", idx), {30'd0, done_o, busy_o}, 32'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        bit ok;
        //           dict                                                      len dists                      nd  bd     bi      err chr end rd
        vecs[0] = '{96'({"ab", 8'h00, "cd", 8'h00, 8'h01}),                    7, 32'({8'd2, 8'd1}),          2, 8'd1,  16'd1, 1'b0, 4, 2, 7};
        vecs[1] = '{96'({"a", 8'h00, "b", 8'h00, "c", 8'h00, 8'h01}),          7, 32'({8'd3, 8'd1, 8'd1}),    3, 8'd1,  16'd1, 1'b0, 3, 3, 7};
        vecs[2] = '{96'({"a", 8'h00, "b", 8'h00, "c", 8'h00, 8'h01}),          7, 32'({8'd5, 8'd0}),          2, 8'd0,  16'd1, 1'b0, 2, 2, 4};
        vecs[3] = '{96'({8'h00, "x", 8'h00, 8'h01}),                           4, 32'({8'd7, 8'd4}),          2, 8'd4,  16'd1, 1'b0, 1, 2, 4};
        vecs[4] = '{96'({"ab", 8'h00, "cd", 8'h01}),                           6, 32'(8'd9),                  1, 8'd9,  16'd0, 1'b0, 4, 1, 6};
        vecs[5] = '{96'(8'h01),                                                1, 32'd0,                      0, 8'hFF, 16'd0, 1'b0, 0, 0, 1};
        vecs[6] = '{96'({"a", 8'h00, "b", 8'h00, 8'h01}),                      5, 32'({8'd2, 8'd2}),          2, 8'd2,  16'd0, 1'b0, 2, 2, 5};
        vecs[7] = '{96'({"a", 8'h00, 8'h01}),                                  3, 32'(8'hFF),                 1, 8'hFF, 16'd0, 1'b0, 1, 1, 3};
        vecs[8] = '{96'({"a", 8'h00, "b", 8'h00, "c", 8'h00, 8'h01}),          7, 32'({8'd8, 8'd3, 8'd6}),    3, 8'd3,  16'd1, 1'b0, 3, 3, 7};

        mem[16'hFFFE] = "x";
        mem[16'hFFFF] = "y";

        // Reset values.
        repeat (3) @(negedge clk_i);
        check("rst_bus", {29'd0, cyc_o, stb_o, we_o}, 32'd0);
        check("rst_adr", 32'(adr_o), 32'h0000);
        check("rst_adr_hi", 32'(adr_h), 32'hFFFE);
        check("rst_best", {8'd0, best_distance_o, best_index_o}, 32'h00FF_0000);
        check("rst_status", {26'd0, busy_o, done_o, error_o, word_start_o, char_valid_o, word_end_o}, 32'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Bus error on the third read.
        mem[0] = "a"; mem[1] = "b"; mem[2] = "c"; mem[3] = 8'h00; mem[4] = 8'h01;
        exp_char_q.delete();
        exp_char_q.push_back("a");
        exp_char_q.push_back("b");
        n_chars = 0; reads = 0; err_on_read = 3;
        enabled = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            if (err_i) begin
                ok = 1'b1;
                break;
            end
        end
        check("err_seen", 32'(ok), 32'd1);
        @(negedge clk_i);
        check("err_bus_drop", {30'd0, cyc_o, stb_o}, 32'd0);
        check("err_flag", 32'(error_o), 32'd1);
        @(negedge clk_i);
        check("err_done", 32'(done_o), 32'd1);
        check("err_chars", 32'(n_chars), 32'd2);
        enabled = 1'b0; err_on_read = 0;
        repeat (2) @(negedge clk_i);

        // Abort while a slow read is outstanding.
        exp_char_q.delete();
        n_chars = 0; n_ends = 0; ack_delay = 4;
        enabled = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (stb_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_stb_seen", 32'(ok), 32'd1);
        enabled = 1'b0;
        @(negedge clk_i);
        check("abort_cyc_held", {30'd0, cyc_o, stb_o}, 32'd3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i);
            if (ack_i) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_ack_seen", 32'(ok), 32'd1);
        @(negedge clk_i);
        check("abort_bus_drop", {30'd0, cyc_o, stb_o}, 32'd0);
        repeat (4) @(negedge clk_i);
        check("abort_status", {29'd0, busy_o, done_o, error_o}, 32'd0);
        check("abort_no_chars", 32'(n_chars + n_ends), 32'd0);
        ack_delay = 0;

        // Reset in the middle of a scan.
        mem[0] = "a"; mem[1] = 8'h00; mem[2] = "b"; mem[3] = "c"; mem[4] = "d";
        mem[5] = "e"; mem[6] = 8'h00; mem[7] = 8'h01;
        exp_char_q.delete();
        exp_char_q.push_back("a"); exp_char_q.push_back("b"); exp_char_q.push_back("c");
        exp_char_q.push_back("d"); exp_char_q.push_back("e");
        dist_q.delete();
        dist_q.push_back(8'd3);
        n_chars = 0;
        enabled = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (n_chars >= 2 && stb_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("midrst_reached", 32'(ok), 32'd1);
        check("midrst_best_before", 32'(best_distance_o), 32'd3);
        rst_i = 1'b1;
        enabled = 1'b0;
        @(negedge clk_i);
        check("midrst_bus_drop", {30'd0, cyc_o, stb_o}, 32'd0);
        check("midrst_adr", 32'(adr_o), 32'h0000);
        check("midrst_best", {8'd0, best_distance_o, best_index_o}, 32'h00FF_0000);
        check("midrst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        dist_q.delete();
        repeat (2) @(negedge clk_i);

        // Recovery after abort and reset.
        run_vec(0);

        // Address overflow at the top of memory.
        reads_h = 0; n_chars_h = 0;
        en_h = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (done_h) begin
                ok = 1'b1;
                break;
            end
        end
        check("ovf_done", 32'(ok), 32'd1);
        check("ovf_error", 32'(error_h), 32'd1);
        check("ovf_chars", 32'(n_chars_h), 32'd1);
        check("ovf_reads", 32'(reads_h), 32'd2);
        check("ovf_adr_hold", 32'(adr_h), 32'hFFFF);
        check("ovf_adr_never_zero", 32'(adr_zero_h), 32'd0);
        en_h = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
